// File: rtl/wb_regfile.sv
// Writeback stage: picks the writeback source, commits it to a 32-entry register file,
// and serves two read ports with same-cycle write-through bypass plus a retired-write counter.
`timescale 1ns/1ps

module wb_regfile_rdport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic [ADDR_WIDTH-1:0]               idx,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
    input  logic                                bypWe,
    input  logic [ADDR_WIDTH-1:0]               bypIdx,
    input  logic [DATA_WIDTH-1:0]               bypData,
    output logic [DATA_WIDTH-1:0]               data
);
    always_comb begin
        data = regs[idx];
        if (idx == '0)
            data = '0;
        else if (bypWe && (idx == bypIdx))
            data = bypData;
    end
endmodule

module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite_in,
    input  logic [1:0]            MemtoReg_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] link_addr_in,
    input  logic [ADDR_WIDTH-1:0] write_reg_in,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic [DATA_WIDTH-1:0] wb_data_out,
    output logic                  wb_we_out,
    output logic [31:0]           wb_count
);
    localparam int NUM_PORTS = 2;

    if (NUM_REGS != 2**ADDR_WIDTH) begin : gBadCfg
        $error("wb_regfile: NUM_REGS must equal 2**ADDR_WIDTH");
    end

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
    logic [DATA_WIDTH-1:0]                wbData;
    logic                                 wbWe;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] readIdx;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] readData;

    // Encoding 11 is reserved and falls back to the ALU result.
    always_comb begin
        wbData = alu_result_in;
        case (MemtoReg_in)
            2'b01:   wbData = mem_data_in;
            2'b10:   wbData = link_addr_in;
            default: wbData = alu_result_in;
        endcase
    end

    assign wbWe        = RegWrite_in && (write_reg_in != '0);
    assign wb_data_out = wbData;
    assign wb_we_out   = wbWe;

    // r0 is never a write target because wbWe excludes index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs <= '0;
        else if (wbWe)
            regs[write_reg_in] <= wbData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_count <= '0;
        else if (wbWe)
            wb_count <= wb_count + 32'd1;
    end

    assign readIdx = {read_reg2, read_reg1};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        wb_regfile_rdport #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .NUM_REGS  (NUM_REGS)
        ) uPort (
            .idx    (readIdx[p]),
            .regs   (regs),
            .bypWe  (wbWe),
            .bypIdx (write_reg_in),
            .bypData(wbData),
            .data   (readData[p])
        );
    end

    assign read_data1 = readData[0];
    assign read_data2 = readData[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// checked against an array-based register model.
`timescale 1ns/1ps

module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_in;
    logic [1:0]  MemtoReg_in;
    logic [31:0] mem_data_in, alu_result_in, link_addr_in;
    logic [4:0]  write_reg_in, read_reg1, read_reg2;
    logic [31:0] read_data1, read_data2, wb_data_out, wb_count;
    logic        wb_we_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];
    logic [31:0] expCount;

    wb_regfile dut (
        .clk(clk), .rst(rst), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .mem_data_in(mem_data_in), .alu_result_in(alu_result_in), .link_addr_in(link_addr_in),
        .write_reg_in(write_reg_in), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2), .wb_data_out(wb_data_out),
        .wb_we_out(wb_we_out), .wb_count(wb_count)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] srcVal();
        if (MemtoReg_in == 2'b01) return mem_data_in;
        if (MemtoReg_in == 2'b10) return link_addr_in;
        return alu_result_in;
    endfunction

    function automatic logic expWe();
        return RegWrite_in && (write_reg_in != 5'd0);
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (expWe() && idx == write_reg_in) return srcVal();
        return model[idx];
    endfunction

    task automatic drive(input logic we, input logic [1:0] sel, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [31:0] link, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite_in = we; MemtoReg_in = sel; mem_data_in = mem; alu_result_in = alu;
        link_addr_in = link; write_reg_in = rd; read_reg1 = r1; read_reg2 = r2;
    endtask

    // Commit the pending write to the model at the edge, then return to the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst && expWe()) begin
            model[write_reg_in] = srcVal();
            expCount = expCount + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
            #1;
            checks++;
            if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
                failures++;
                $display("FAIL reset_read idx=%0d got=%h/%h exp=0", i, read_data1, read_data2);
            end
        end
        checks++;
        if (wb_count !== 32'd0) begin
            failures++; $display("FAIL reset_count got=%h exp=0", wb_count);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 2'b00, 32'h0, 32'h0000_1234, 32'h0, 5'd5, 5'd5, 5'd0);
        #1;
        checks++;
        if (read_data1 !== 32'h1234) begin
            failures++; $display("FAIL bypass_same_cycle got=%h exp=00001234", read_data1);
        end
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0);
        #1;
        checks++;
        if (read_data1 !== 32'h1234) begin
            failures++; $display("FAIL bypass_stored got=%h exp=00001234", read_data1);
        end
        checks++;
        if (wb_count !== 32'd1) begin
            failures++; $display("FAIL bypass_count got=%0d exp=1", wb_count);
        end
    endtask

    task automatic test_src_select();
        drive(1'b1, 2'b01, 32'hDEAD_BEEF, 32'h1111, 32'h2222, 5'd6, 5'd0, 5'd0); #1;
        checks++;
        if (wb_data_out !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL src_mem wb_data got=%h exp=deadbeef", wb_data_out);
        end
        tick();
        drive(1'b1, 2'b10, 32'h3333, 32'h4444, 32'h0040_0008, 5'd7, 5'd0, 5'd0); tick();
        drive(1'b1, 2'b11, 32'h5555, 32'h55, 32'h6666, 5'd8, 5'd0, 5'd0); tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd6, 5'd7); #1;
        checks++;
        if (read_data1 !== 32'hDEAD_BEEF || read_data2 !== 32'h0040_0008) begin
            failures++;
            $display("FAIL src_r6_r7 got=%h/%h exp=deadbeef/00400008", read_data1, read_data2);
        end
        read_reg1 = 5'd8; #1;
        checks++;
        if (read_data1 !== 32'h55) begin
            failures++; $display("FAIL src_reserved_r8 got=%h exp=00000055", read_data1);
        end
        checks++;
        if (wb_count !== 32'd4) begin
            failures++; $display("FAIL src_count got=%0d exp=4", wb_count);
        end
    endtask

    task automatic test_r0();
        logic [31:0] cnt0, r9;
        cnt0 = expCount; r9 = model[9];
        drive(1'b1, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0); #1;
        checks++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0 || wb_we_out !== 1'b0) begin
            failures++;
            $display("FAIL r0_write got=%h/%h we=%b exp=0/0 we=0", read_data1, read_data2, wb_we_out);
        end
        tick(); #1;
        checks++;
        if (wb_count !== cnt0 || read_data1 !== 32'd0) begin
            failures++; $display("FAIL r0_after got cnt=%0d r0=%h exp cnt=%0d r0=0", wb_count, read_data1, cnt0);
        end
        drive(1'b0, 2'b00, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd9, 5'd9, 5'd9); tick(); #1;
        checks++;
        if (read_data1 !== r9 || wb_count !== cnt0) begin
            failures++; $display("FAIL no_we_r9 got=%h cnt=%0d exp=%h cnt=%0d", read_data1, wb_count, r9, cnt0);
        end
    endtask

    task automatic test_dual_bypass();
        drive(1'b1, 2'b00, 32'h0, 32'hA5A5_A5A5, 32'h0, 5'd10, 5'd10, 5'd10); #1;
        checks++;
        if (read_data1 !== 32'hA5A5_A5A5 || read_data2 !== 32'hA5A5_A5A5) begin
            failures++; $display("FAIL dual_bypass got=%h/%h exp=a5a5a5a5", read_data1, read_data2);
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'b00, 32'h0, $urandom | 32'h1, 32'h0, 5'(i), 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd4);
        #2 rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        expCount = 32'd0;
        #1;
        checks++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0 || wb_count !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got=%h/%h cnt=%0d exp=0/0 cnt=0", read_data1, read_data2, wb_count);
        end
        drive(1'b1, 2'b10, 32'h0, 32'h0, 32'h1357_9BDF, 5'd12, 5'd12, 5'd2); #1;
        checks++;
        if (read_data1 !== 32'h1357_9BDF || read_data2 !== 32'd0) begin
            failures++; $display("FAIL reset_bypass got=%h/%h exp=13579bdf/0", read_data1, read_data2);
        end
        #1;
        RegWrite_in = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h0, 32'h77, 32'h0, 5'd3, 5'd0, 5'd0); tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd12); #1;
        checks++;
        if (read_data1 !== 32'h77 || read_data2 !== 32'd0 || wb_count !== 32'd1) begin
            failures++;
            $display("FAIL post_reset_write got=%h/%h cnt=%0d exp=77/0 cnt=1", read_data1, read_data2, wb_count);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd;
        for (int n = 0; n < 300; n++) begin
            rd = 5'($urandom_range(0, 31));
            drive(($urandom % 4) != 0, 2'($urandom), $urandom, $urandom, $urandom, rd,
                  ($urandom % 3 == 0) ? rd : 5'($urandom), ($urandom % 3 == 0) ? rd : 5'($urandom));
            #1;
            checks++;
            if (wb_data_out !== srcVal() || wb_we_out !== expWe()) begin
                failures++;
                $display("FAIL rand_wb n=%0d got=%h we=%b exp=%h we=%b", n, wb_data_out, wb_we_out, srcVal(), expWe());
            end
            checks++;
            if (read_data1 !== expRead(read_reg1) || read_data2 !== expRead(read_reg2)) begin
                failures++;
                $display("FAIL rand_read n=%0d idx=%0d/%0d got=%h/%h exp=%h/%h", n, read_reg1, read_reg2,
                         read_data1, read_data2, expRead(read_reg1), expRead(read_reg2));
            end
            tick();
            #1;
            checks++;
            if (wb_count !== expCount) begin
                failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, wb_count, expCount);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        expCount = 32'd0;
        rst = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #3;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_bypass();
        test_src_select();
        test_r0();
        test_dual_bypass();
        test_async_reset();
        @(negedge clk);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
